idex_pipe_reg: RTL
==================

// Module: idex_pipe_reg
// PURPOSE
//  Parametrised ID/EX pipeline register for the RV32 core, successor to the fixed-width IDEX stage.
//  Captures decoded operands, immediate, PC, destination and control bundle under valid/ready handshake.
//  Adds flush, optional skid buffer, load-use hazard bubble insertion and a saturating bubble counter.
//  Sits between decode (regfile read, immediate generation, ControlUnit) and the ALU/Dmem execute stage.
// PARAMETERS
//  XLEN    32  datapath width of PC, rs1/rs2 values and immediate
//  CTRL_W  12  width of opaque control bundle (ALUControl, ALUSource*, Dmem*, RegWrite), passed through untouched
//  SKID    1   1 = two-entry stage with registered in_ready; 0 = single entry, combinational in_ready
//  CNT_W   16  width of bubble counter
// PORTS
//  CLK          in   1       clock, all state updates on rising edge
//  RSTN         in   1       asynchronous active-low reset
//  in_valid     in   1       decode presents a valid instruction
//  in_ready     out  1       stage accepts this cycle (transfer = in_valid & in_ready)
//  in_pc        in   XLEN    PC of instruction
//  in_rs1_val   in   XLEN    regfile rs1 value
//  in_rs2_val   in   XLEN    regfile rs2 value
//  in_imm       in   XLEN    sign-extended/shifted immediate
//  in_rs1_idx   in   5       rs1 index (hazard check)
//  in_rs2_idx   in   5       rs2 index (hazard check)
//  in_uses_rs2  in   1       instruction reads rs2
//  in_rd        in   5       destination index
//  in_memread   in   1       instruction is a load
//  in_ctrl      in   CTRL_W  control bundle
//  flush        in   1       kill all held instructions (branch/jump redirect)
//  out_valid    out  1       execute-side entry valid
//  out_ready    in   1       execute accepts (transfer = out_valid & out_ready)
//  out_pc, out_rs1_val, out_rs2_val, out_imm  out  XLEN  registered copies
//  out_rd       out  5       registered copy;  out_memread out 1;  out_ctrl out CTRL_W
//  bubble_cnt   out  CNT_W   count of load-use bubbles inserted
// BEHAVIOUR
//  Reset (RSTN=0, async): out_valid=0, skid_valid=0, all out_* data=0, bubble_cnt=0; in_ready=0 while RSTN=0.
//  Latency: 1 cycle from input transfer to out_valid when execute side not stalled.
//  Hazard: hz = out_valid & out_memread & out_rd!=0 & in_valid &
//          (in_rs1_idx==out_rd | (in_uses_rs2 & in_rs2_idx==out_rd)). Checked against head entry only.
//  SKID=0: in_ready = RSTN & !flush & !hz & (!out_valid | out_ready).
//  SKID=1: in_ready = registered !skid_valid, then gated combinationally by !flush & !hz.
//   - transfer while head empty or head leaving -> data into head;
//   - transfer while head held (out_valid & !out_ready) -> data into skid, skid_valid=1;
//   - head leaves with skid_valid=1 -> skid moves to head, skid_valid=0; order strictly FIFO.
//  Bubble: hz & out_ready -> head retires, out_valid=0 next cycle (bubble), no input taken;
//   bubble_cnt += 1, saturating at all-ones. hz & !out_ready -> plain stall, no count.
//  Flush (sync, highest priority): next edge out_valid=0, skid_valid=0, no input accepted that cycle,
//   bubble_cnt unchanged; out_* data may hold stale values while out_valid=0.
//  Simultaneous flush & out_ready: current head still counts as transferred this cycle; only later entries killed.
//  Data registers load only on transfer; held values stable while out_valid & !out_ready.
//  Reset mid-operation: all entries dropped immediately, no partial state survives.
// TESTING
//  Stream 8 back-to-back instrs, out_ready=1 -> out_pc sequence 0x00..0x1C, 1-cycle latency, no gaps.
//  out_ready=0 for 3 cycles with SKID=1 -> 2 entries held, in_ready=0 after 2nd; release -> order preserved.
//  Head lw x5 (out_memread=1, out_rd=5), in add x6,x5,x1 -> one bubble, bubble_cnt 0->1, add issued next.
//  lw x0 followed by use of x0 -> no bubble, bubble_cnt stays 0.
//  flush=1 with head+skid valid -> next cycle out_valid=0, in_ready=1, no old PC ever appears at out.
//  RSTN pulsed low mid-stream (async, between edges) -> out_valid=0, bubble_cnt=0 immediately.

Source files
------------

// File: rtl/idex_pipe_reg_if.sv
// ID/EX stage bundle: decode-side request, execute-side response and redirect flush.
// master = decode/execute environment, slave = the pipeline register itself.
interface idex_pipe_reg_if #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 12
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   in_pc;
    logic [XLEN-1:0]   in_rs1_val;
    logic [XLEN-1:0]   in_rs2_val;
    logic [XLEN-1:0]   in_imm;
    logic [4:0]        in_rs1_idx;
    logic [4:0]        in_rs2_idx;
    logic              in_uses_rs2;
    logic [4:0]        in_rd;
    logic              in_memread;
    logic [CTRL_W-1:0] in_ctrl;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [XLEN-1:0]   out_rs1_val;
    logic [XLEN-1:0]   out_rs2_val;
    logic [XLEN-1:0]   out_imm;
    logic [4:0]        out_rd;
    logic              out_memread;
    logic [CTRL_W-1:0] out_ctrl;

    modport master (
        output in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm, in_rs1_idx, in_rs2_idx,
               in_uses_rs2, in_rd, in_memread, in_ctrl, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd,
               out_memread, out_ctrl
    );

    modport slave (
        input  in_valid, in_pc, in_rs1_val, in_rs2_val, in_imm, in_rs1_idx, in_rs2_idx,
               in_uses_rs2, in_rd, in_memread, in_ctrl, flush, out_ready,
        output in_ready, out_valid, out_pc, out_rs1_val, out_rs2_val, out_imm, out_rd,
               out_memread, out_ctrl
    );
endinterface

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register: valid/ready stage with optional skid entry, flush,
// load-use bubble insertion and a saturating bubble counter.
module idex_pipe_reg #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned CTRL_W = 12,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             CLK,
    input  logic             RSTN,
    idex_pipe_reg_if.slave   bus,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_val;
        logic [XLEN-1:0]   rs2_val;
        logic [XLEN-1:0]   imm;
        logic [4:0]        rd;
        logic              memread;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    entry_t           in_entry;
    entry_t           head_q, head_d;
    entry_t           skid_q, skid_d;
    logic             head_valid_q, head_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hz;
    logic             xfer;
    logic             head_free;

    // Pack the incoming instruction into one entry.
    always_comb begin
        in_entry.pc      = bus.in_pc;
        in_entry.rs1_val = bus.in_rs1_val;
        in_entry.rs2_val = bus.in_rs2_val;
        in_entry.imm     = bus.in_imm;
        in_entry.rd      = bus.in_rd;
        in_entry.memread = bus.in_memread;
        in_entry.ctrl    = bus.in_ctrl;
    end

    // Load-use hazard: only the head entry can be the producing load.
    always_comb begin
        hz = head_valid_q & head_q.memread & (head_q.rd != 5'd0) & bus.in_valid &
             ((bus.in_rs1_idx == head_q.rd) |
              (bus.in_uses_rs2 & (bus.in_rs2_idx == head_q.rd)));
    end

    generate
        if (SKID != 0) begin : g_skid
            logic rdy_q;

            // Registered ready: free while the skid slot is empty.
            always_ff @(posedge CLK or negedge RSTN) begin
                if (!RSTN) begin
                    rdy_q <= 1'b1;
                end else begin
                    rdy_q <= !skid_valid_d;
                end
            end

            assign bus.in_ready = RSTN & rdy_q & !bus.flush & !hz;
        end else begin : g_noskid
            assign bus.in_ready = RSTN & !bus.flush & !hz & (!head_valid_q | bus.out_ready);
        end
    endgenerate

    assign xfer      = bus.in_valid & bus.in_ready;
    assign head_free = !head_valid_q | bus.out_ready;

    // Next-state: flush kills everything; otherwise FIFO refill of head from skid or input.
    always_comb begin
        head_d       = head_q;
        head_valid_d = head_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        cnt_d        = cnt_q;
        if (bus.flush) begin
            head_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (hz && bus.out_ready && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (head_free) begin
                if (skid_valid_q) begin
                    head_d       = skid_q;
                    head_valid_d = 1'b1;
                    skid_valid_d = 1'b0;
                end else if (xfer) begin
                    head_d       = in_entry;
                    head_valid_d = 1'b1;
                end else begin
                    // Nothing to refill with; a hazard lands here as a bubble.
                    head_valid_d = 1'b0;
                end
            end else if (xfer) begin
                // Only reachable with the skid slot enabled: head held, park the newcomer.
                skid_d       = in_entry;
                skid_valid_d = 1'b1;
            end
        end
    end

    // Stage state registers; async reset drops every entry at once.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            head_q       <= '0;
            skid_q       <= '0;
            head_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            head_q       <= head_d;
            skid_q       <= skid_d;
            head_valid_q <= head_valid_d;
            skid_valid_q <= skid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    // Execute-side view of the head entry.
    always_comb begin
        bus.out_valid   = head_valid_q;
        bus.out_pc      = head_q.pc;
        bus.out_rs1_val = head_q.rs1_val;
        bus.out_rs2_val = head_q.rs2_val;
        bus.out_imm     = head_q.imm;
        bus.out_rd      = head_q.rd;
        bus.out_memread = head_q.memread;
        bus.out_ctrl    = head_q.ctrl;
        bubble_cnt      = cnt_q;
    end

endmodule
